serdes_ber_checker: RTL and testbench
=====================================

Name: serdes_ber_checker

Overview:
Parametrised multi-lane PRBS checker that closes the loop after the RX chain (PRBS -> gray encoder -> PAM4 encoder -> channel -> noise -> DFE -> PAM4 decoder -> gray decoder).
- Self-synchronises each lane to the received PRBS bit stream.
- Tracks lock per lane and counts bits and errors over a programmable measurement window.
- Generalises the single-lane, PRBS7-only, display-only datapath with selectable PRBS order, lane count, lock/loss hysteresis and a BER window.

Parameters:
LANES, 1, number of independent checker lanes
PRBS_ORDER, 7, polynomial; legal values 7 (x^7+x^6+1), 9 (x^9+x^5+1), 15 (x^15+x^14+1), 23 (x^23+x^18+1), 31 (x^31+x^28+1); any other value is an elaboration error
LOCK_CNT, 32, consecutive correct predictions needed to declare lock
LOSS_WINDOW, 64, locked bits per loss-evaluation window
LOSS_THRESH, 8, errors within one loss window that force unlock
CNT_W, 32, width of the bit/error counters and of window_bits

Ports:
clk  in  1  system clock
rstn  in  1  synchronous, active-low reset
data_in  in  LANES  recovered bit per lane (gray decoder data_out)
data_in_valid  in  LANES  per-lane bit qualifier
start  in  1  pulse: clear counters and begin a measurement
window_bits  in  CNT_W  locked bits per lane to measure; 0 = free-run, never done
locked  out  LANES  lane is in the LOCKED state
lost_flag  out  LANES  sticky: lane left LOCKED while busy
bit_count  out  LANES*CNT_W  per-lane locked bits counted (lane l at [l*CNT_W +: CNT_W])
err_count  out  LANES*CNT_W  per-lane errors counted
busy  out  1  measurement active
done  out  1  all lanes reached window_bits

Behaviour:
Reset
- Synchronous: on clk rising edge with rstn=0, all outputs, states and registers go to 0. This also applies mid-measurement.

General
- A lane changes state only on cycles where its data_in_valid=1. Gaps are transparent.
- All outputs are registered. Effects of a valid bit appear on the cycle after it.
- Predicted bit p = sr[ORDER-1] ^ sr[TAP-1]. sr is the per-lane ORDER-bit shift register; the newest bit enters at sr[0].

Per-lane state machine
- HUNT: shift data_in into sr and count fill bits. After ORDER bits go to SYNC, unless sr is all zero; in that case stay in HUNT and restart the fill count (degenerate-stream guard).
- SYNC: compare data_in with p, then shift data_in into sr.
  - Match: increment the consecutive counter. At LOCK_CNT go to LOCKED.
  - Mismatch: clear the consecutive counter and stay in SYNC.
  - sr becoming all zero returns the lane to HUNT.
- LOCKED: sr runs free (shift in p, not data_in). err = data_in ^ p.
  - Loss window counts LOSS_WINDOW valid bits. The window error count resets at each window boundary.
  - If window errors reach LOSS_THRESH: go to HUNT immediately (on the same bit). locked drops the next cycle. If busy, set lost_flag.

Measurement
- start=1: next cycle clears bit_count, err_count, lost_flag and done, and sets busy=1.
- start has priority over a simultaneous valid bit; that bit is not counted.
- While busy and the lane is LOCKED, each valid bit increments bit_count and each error increments err_count. The bit that causes unlock is counted.
- Counting pauses while a lane is not LOCKED.
- Counters saturate at all-ones.
- A lane is finished when bit_count == window_bits (window_bits != 0). It then stops counting.
- When all lanes are finished: done=1 and busy=0 on the same cycle. done holds until the next start or reset.
- window_bits is sampled at start. Later changes are ignored.
- start while busy restarts the measurement.

Optional Feature:
Macro SERDES_BER_ERR_INJECT_EN.
- Defined: adds input port inject_err (LANES). A pulse on lane l arms a one-shot inversion of the next valid data_in on that lane before comparison. Arming is ignored if already armed. The inversion is consumed in any state.
- Undefined: the port is absent and no inversion logic exists.

Test Plan:
1. LANES=1, PRBS_ORDER=7: clean PRBS7 stream, valid every cycle -> locked=1 the cycle after the 39th valid bit. Then start with window_bits=1000 -> after 1000 bits done=1, busy=0, bit_count=1000, err_count=0.
2. Same setup, flip bits 100, 200, 300 of the window -> err_count=3, locked stays 1, lost_flag=0.
3. Flip 8 consecutive bits mid-window -> locked drops one cycle after the 8th error, lost_flag=1, bit_count frozen. Relocks 39 good bits later and counting resumes.
4. data_in_valid asserted 1 cycle in 3 over a 1000-bit window -> identical counts to scenario 1; elapsed time is about 3x.
5. LANES=4: lanes 0, 1, 3 clean; lane 2 held at constant 0 -> lane 2 never locks, done stays 0. Lanes 0, 1, 3 reach window_bits=500 with err_count=0.
6. rstn=0 for one cycle at bit 400 of a 1000-bit window -> all outputs 0 next cycle. Relock and a fresh start behave as in scenario 1. With SERDES_BER_ERR_INJECT_EN defined, 5 inject pulses -> err_count=5.

Source files
------------

// File: rtl/serdes_ber_checker.sv
// Multi-lane PRBS checker: self-synchronising per-lane lock FSM, lock-loss hysteresis and windowed BER counters.
// Optional one-shot error injection (inject_err port) is compiled in with `define SERDES_BER_ERR_INJECT_EN.
module serdes_ber_checker #(
  parameter int LANES       = 1,
  parameter int PRBS_ORDER  = 7,
  parameter int LOCK_CNT    = 32,
  parameter int LOSS_WINDOW = 64,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [LANES-1:0]       data_in,
  input  logic [LANES-1:0]       data_in_valid,
`ifdef SERDES_BER_ERR_INJECT_EN
  input  logic [LANES-1:0]       inject_err,
`endif
  input  logic                   start,
  input  logic [CNT_W-1:0]       window_bits,
  output logic [LANES-1:0]       locked,
  output logic [LANES-1:0]       lost_flag,
  output logic [LANES*CNT_W-1:0] bit_count,
  output logic [LANES*CNT_W-1:0] err_count,
  output logic                   busy,
  output logic                   done
);

  localparam int TAP = (PRBS_ORDER == 7)  ? 6  :
                       (PRBS_ORDER == 9)  ? 5  :
                       (PRBS_ORDER == 15) ? 14 :
                       (PRBS_ORDER == 23) ? 18 :
                       (PRBS_ORDER == 31) ? 28 : 0;
  localparam int TAP_IDX = (TAP == 0) ? 0 : TAP - 1;
  localparam int SCW = $clog2(LOCK_CNT + PRBS_ORDER + 1);
  localparam int WCW = $clog2(LOSS_WINDOW + 1);
  localparam int ECW = $clog2(LOSS_THRESH + 1);

  generate
    if (TAP == 0) begin : g_bad_order
      $error("serdes_ber_checker: unsupported PRBS_ORDER %0d", PRBS_ORDER);
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } lane_state_e;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [LANES-1:0] fin_d;

  // Handshake: a lane consumes data_in only on cycles with data_in_valid=1; there is no backpressure.
  genvar l;
  generate
    for (l = 0; l < LANES; l++) begin : g_lane
      lane_state_e           state_q, state_d;
      logic [PRBS_ORDER-1:0] sr_q, sr_d;
      logic [SCW-1:0]        cnt_q, cnt_d;
      logic [WCW-1:0]        wcnt_q, wcnt_d;
      logic [ECW-1:0]        werr_q, werr_d, werr_n;
      logic [CNT_W-1:0]      bitc_q, bitc_d, errc_q, errc_d;
      logic                  lost_q, lost_d;
      logic                  din, pred, err, unlock, fin_q;

`ifdef SERDES_BER_ERR_INJECT_EN
      logic arm_q, arm_d;

      always_comb begin
        arm_d = arm_q;
        if (data_in_valid[l] && arm_q) begin
          arm_d = 1'b0;
        end else if (inject_err[l]) begin
          arm_d = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!rstn) arm_q <= 1'b0;
        else       arm_q <= arm_d;
      end

      assign din = data_in[l] ^ arm_q;
`else
      assign din = data_in[l];
`endif

      assign pred   = sr_q[PRBS_ORDER-1] ^ sr_q[TAP_IDX];
      assign err    = din ^ pred;
      assign werr_n = werr_q + ECW'(err);
      assign fin_q  = (win_q != '0) && (bitc_q == win_q);

      always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        werr_d  = werr_q;
        unlock  = 1'b0;
        if (data_in_valid[l]) begin
          case (state_q)
            ST_HUNT: begin
              sr_d = {sr_q[PRBS_ORDER-2:0], din};
              if (cnt_q == SCW'(PRBS_ORDER - 1)) begin
                cnt_d = '0;
                if (sr_d != '0) state_d = ST_SYNC;
              end else begin
                cnt_d = cnt_q + SCW'(1);
              end
            end
            ST_SYNC: begin
              sr_d = {sr_q[PRBS_ORDER-2:0], din};
              if (sr_d == '0) begin
                state_d = ST_HUNT;
                cnt_d   = '0;
              end else if (din == pred) begin
                if (cnt_q == SCW'(LOCK_CNT - 1)) begin
                  state_d = ST_LOCKED;
                  cnt_d   = '0;
                  wcnt_d  = '0;
                  werr_d  = '0;
                end else begin
                  cnt_d = cnt_q + SCW'(1);
                end
              end else begin
                cnt_d = '0;
              end
            end
            ST_LOCKED: begin
              // Free-running reference: errors on the line never corrupt the predictor.
              sr_d = {sr_q[PRBS_ORDER-2:0], pred};
              if (werr_n >= ECW'(LOSS_THRESH)) begin
                state_d = ST_HUNT;
                cnt_d   = '0;
                wcnt_d  = '0;
                werr_d  = '0;
                unlock  = 1'b1;
              end else if (wcnt_q == WCW'(LOSS_WINDOW - 1)) begin
                wcnt_d = '0;
                werr_d = '0;
              end else begin
                wcnt_d = wcnt_q + WCW'(1);
                werr_d = werr_n;
              end
            end
            default: state_d = ST_HUNT;
          endcase
        end
      end

      always_comb begin
        bitc_d = bitc_q;
        errc_d = errc_q;
        lost_d = lost_q;
        if (start) begin
          bitc_d = '0;
          errc_d = '0;
          lost_d = 1'b0;
        end else if (busy_q) begin
          if (data_in_valid[l] && (state_q == ST_LOCKED) && !fin_q) begin
            if (bitc_q != '1) bitc_d = bitc_q + CNT_W'(1);
            if (err && (errc_q != '1)) errc_d = errc_q + CNT_W'(1);
          end
          if (unlock) lost_d = 1'b1;
        end
      end

      assign fin_d[l] = (win_q != '0) && (bitc_d == win_q);

      always_ff @(posedge clk) begin
        if (!rstn) begin
          state_q <= ST_HUNT;
          sr_q    <= '0;
          cnt_q   <= '0;
          wcnt_q  <= '0;
          werr_q  <= '0;
          bitc_q  <= '0;
          errc_q  <= '0;
          lost_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          sr_q    <= sr_d;
          cnt_q   <= cnt_d;
          wcnt_q  <= wcnt_d;
          werr_q  <= werr_d;
          bitc_q  <= bitc_d;
          errc_q  <= errc_d;
          lost_q  <= lost_d;
        end
      end

      assign locked[l]                    = (state_q == ST_LOCKED);
      assign lost_flag[l]                 = lost_q;
      assign bit_count[l*CNT_W +: CNT_W]  = bitc_q;
      assign err_count[l*CNT_W +: CNT_W]  = errc_q;
    end
  endgenerate

  // Restart has priority; otherwise the measurement closes once every lane has hit its window.
  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    win_d  = win_q;
    if (start) begin
      busy_d = 1'b1;
      done_d = 1'b0;
      win_d  = window_bits;
    end else if (busy_q && (&fin_d)) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      win_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      win_q  <= win_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serdes_ber_checker.sv
// Directed bench for serdes_ber_checker: two PRBS7 lanes, lock/loss, windows, gaps, reset and restart.
module tb_serdes_ber_checker;

  localparam int LANES = 2;
  localparam int CNT_W = 32;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic [LANES-1:0]       data_in = '0;
  logic [LANES-1:0]       data_in_valid = '0;
  logic                   start = 1'b0;
  logic [CNT_W-1:0]       window_bits = '0;
  logic [LANES-1:0]       locked, lost_flag;
  logic [LANES*CNT_W-1:0] bit_count, err_count;
  logic                   busy, done;
`ifdef SERDES_BER_ERR_INJECT_EN
  logic [LANES-1:0]       inject_err = '0;
`endif

  serdes_ber_checker #(.LANES(LANES), .PRBS_ORDER(7), .LOCK_CNT(32), .LOSS_WINDOW(64),
                       .LOSS_THRESH(8), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
`ifdef SERDES_BER_ERR_INJECT_EN
    .inject_err    (inject_err),
`endif
    .start         (start),
    .window_bits   (window_bits),
    .locked        (locked),
    .lost_flag     (lost_flag),
    .bit_count     (bit_count),
    .err_count     (err_count),
    .busy          (busy),
    .done          (done)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int       n_checks = 0;
  int       n_fail = 0;
  logic [6:0] gen_q = 7'h7f;
  int       bit_idx = 0;
  int       lock_bits0 = 0;
  int       flip_q[$];
  bit       lane1_zero = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_flip(input int idx);
    foreach (flip_q[i]) if (flip_q[i] == idx) return 1'b1;
    return 1'b0;
  endfunction

  // Drivers: called right after a falling edge, consumed on the next rising edge.
  task automatic put_bit();
    logic b;
    bit   f;
    b = gen_q[6] ^ gen_q[5];
    gen_q = {gen_q[5:0], b};
    bit_idx++;
    lock_bits0++;
    f = is_flip(bit_idx);
    data_in = {(lane1_zero ? 1'b0 : b), b ^ f};
    data_in_valid = 2'b11;
  endtask

  task automatic send_bits(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      put_bit();
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        data_in_valid = '0;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    data_in_valid = '0;
    data_in = '0;
  endtask

  task automatic start_meas(input logic [CNT_W-1:0] w, input bit with_bit);
    @(negedge clk);
    if (with_bit) put_bit();
    else data_in_valid = '0;
    start = 1'b1;
    window_bits = w;
    @(negedge clk);
    start = 1'b0;
    data_in_valid = '0;
    bit_idx = 0;
  endtask

  int k;
  int i0;

  initial begin
    // Reset
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    check_eq("rst_locked", locked, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_bits", bit_count, 0);

    // Clean stream: lock after 39 bits, then a 1000-bit window
    send_bits(38, 0);
    idle();
    check_eq("lock_38", locked, 2'b00);
    send_bits(1, 0);
    idle();
    check_eq("lock_39", locked, 2'b11);
    lock_bits0 = 0;
    start_meas(1000, 1'b0);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_bits0", bit_count, 0);
    send_bits(999, 0);
    idle();
    check_eq("t1_bits999", bit_count[31:0], 999);
    check_eq("t1_done999", done, 0);
    send_bits(1, 0);
    idle();
    check_eq("t1_done", done, 1);
    check_eq("t1_busy_end", busy, 0);
    check_eq("t1_bits", bit_count, {32'd1000, 32'd1000});
    check_eq("t1_errs", err_count, 0);
    send_bits(5, 0);
    idle();
    check_eq("t1_stop", bit_count, {32'd1000, 32'd1000});

    // Isolated errors at window bits 100/200/300 on lane 0
    flip_q = '{100, 200, 300};
    start_meas(1000, 1'b0);
    send_bits(1000, 0);
    idle();
    check_eq("t2_errs", err_count, {32'd0, 32'd3});
    check_eq("t2_locked", locked, 2'b11);
    check_eq("t2_lost", lost_flag, 2'b00);
    check_eq("t2_done", done, 1);
    flip_q.delete();

    // Burst of 8 errors aligned to the start of a loss window on lane 0
    k = lock_bits0;
    i0 = 100 + (64 - ((k + 99) % 64)) % 64;
    for (int j = 0; j < 8; j++) flip_q.push_back(i0 + j);
    start_meas(1000, 1'b0);
    send_bits(i0 + 6, 0);
    idle();
    check_eq("t3_pre_locked", locked, 2'b11);
    check_eq("t3_pre_errs", err_count[31:0], 7);
    send_bits(1, 0);
    idle();
    check_eq("t3_unlock", locked, 2'b10);
    check_eq("t3_lost", lost_flag, 2'b01);
    check_eq("t3_bits0", bit_count[31:0], i0 + 7);
    check_eq("t3_errs0", err_count[31:0], 8);
    check_eq("t3_bits1", bit_count[63:32], i0 + 7);
    send_bits(38, 0);
    idle();
    check_eq("t3_relock38", locked, 2'b10);
    check_eq("t3_frozen", bit_count[31:0], i0 + 7);
    send_bits(1, 0);
    idle();
    check_eq("t3_relock39", locked, 2'b11);
    send_bits(1038 - (i0 + 46), 0);
    idle();
    check_eq("t3_done_early", done, 0);
    check_eq("t3_bits0_999", bit_count[31:0], 999);
    check_eq("t3_bits1_fin", bit_count[63:32], 1000);
    send_bits(1, 0);
    idle();
    check_eq("t3_done", done, 1);
    check_eq("t3_bits_end", bit_count, {32'd1000, 32'd1000});
    check_eq("t3_errs_end", err_count, {32'd0, 32'd8});
    check_eq("t3_lost_end", lost_flag, 2'b01);
    flip_q.delete();

    // Valid one cycle in three
    start_meas(1000, 1'b0);
    send_bits(999, 2);
    idle();
    check_eq("t4_done999", done, 0);
    check_eq("t4_bits999", bit_count, {32'd999, 32'd999});
    send_bits(1, 2);
    idle();
    check_eq("t4_done", done, 1);
    check_eq("t4_bits", bit_count, {32'd1000, 32'd1000});
    check_eq("t4_errs", err_count, 0);

    // Lane 1 held at zero: it drops lock and can never relock
    lane1_zero = 1'b1;
    send_bits(200, 0);
    idle();
    check_eq("t5_lane1_lost", locked, 2'b01);
    start_meas(500, 1'b0);
    send_bits(600, 0);
    idle();
    check_eq("t5_locked", locked, 2'b01);
    check_eq("t5_done", done, 0);
    check_eq("t5_busy", busy, 1);
    check_eq("t5_bits", bit_count, {32'd0, 32'd500});
    check_eq("t5_errs", err_count, 0);
    check_eq("t5_lost", lost_flag, 2'b00);

    // Reset in the middle of a measurement
    @(negedge clk);
    rstn = 1'b0;
    data_in_valid = '0;
    @(negedge clk);
    rstn = 1'b1;
    check_eq("t6_rst_locked", locked, 0);
    check_eq("t6_rst_bits", bit_count, 0);
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_done", done, 0);
    lane1_zero = 1'b0;
    send_bits(38, 0);
    idle();
    check_eq("t6_lock38", locked, 2'b00);
    send_bits(1, 0);
    idle();
    check_eq("t6_lock39", locked, 2'b11);

    // Restart while busy; start-cycle bit not counted; window_bits sampled only at start
    start_meas(1000, 1'b0);
    send_bits(50, 0);
    idle();
    check_eq("t6_bits50", bit_count, {32'd50, 32'd50});
    start_meas(200, 1'b1);
    window_bits = 5;
    check_eq("t6_restart_bits", bit_count, 0);
    check_eq("t6_restart_busy", busy, 1);
    for (int p = 0; p < 5; p++) begin
      send_bits(30, 0);
`ifdef SERDES_BER_ERR_INJECT_EN
      @(negedge clk);
      data_in_valid = '0;
      inject_err = 2'b01;
      @(negedge clk);
      inject_err = '0;
`endif
    end
    send_bits(49, 0);
    idle();
    check_eq("t6_done199", done, 0);
    check_eq("t6_bits199", bit_count, {32'd199, 32'd199});
    send_bits(1, 0);
    idle();
    check_eq("t6_done", done, 1);
    check_eq("t6_bits", bit_count, {32'd200, 32'd200});
`ifdef SERDES_BER_ERR_INJECT_EN
    check_eq("t6_errs", err_count, {32'd0, 32'd5});
`else
    check_eq("t6_errs", err_count, 0);
`endif
    check_eq("t6_locked", locked, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
